axi_to_native_bridge: RTL and testbench
=======================================

# axi_to_native_bridge

Converts AXI4 bursts from the SoC-facing AXI port into per-beat LiteDRAM native-port transactions (cmd / wdata / rdata) for the memory controller crossbar. It sits directly upstream of the native port: it consumes the AXI aw/w/b/ar/r channels and drives native_cmd, wdata and rdata. One burst is in flight at a time. Reads and writes are arbitrated round-robin.

## Interface
Parameters:
- ADDR_W, 32, AXI byte address width and native_cmd_payload_addr width.
- DATA_W, 256, data width for AXI and native; STRB_W = DATA_W/8.
- OFFSET_W, 5, log2(DATA_W/8); the byte offset dropped to form the native word address.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  asynchronous, active-low reset.
- axi_aw_*, axi_ar_*  in (valid, payload) / out (ready)  address channels; addr ADDR_W, burst 2, len 8, size 4, id 1; lock/prot/cache/qos ignored.
- axi_w_*  in/out  valid, ready, last, payload_data DATA_W, payload_strb STRB_W, payload_id 1.
- axi_b_*  out/in  valid, ready, last, payload_resp 2, payload_id 1; first = last = 1 with valid.
- axi_r_*  out/in  valid, ready, first, last, payload_resp 2, payload_data DATA_W, payload_id 1.
- native_cmd_*  out/in  valid, ready, first, last, payload_we 1, payload_addr ADDR_W.
- wdata_*  out/in  valid, ready, first, last, payload_data DATA_W, payload_we STRB_W (byte enables = AXI strb).
- rdata_*  in/out  valid, ready, first, last, payload_data DATA_W.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE: grant goes to the write if only aw_valid is high, to the read if only ar_valid is high. If both are high, grant goes opposite to last_grant. last_grant resets to read, so a write wins the first tie.
  - Granted channel: ready = 1 combinationally in IDLE.
  - On handshake, latch word address = addr >> OFFSET_W (zero-extended), plus len, burst and id.
  - Next state is WRITE or READ.
- WRITE: two independent beat counters, cmd_cnt and dat_cnt, each 0..len.
  - native_cmd_valid = 1 while cmd_cnt <= len, with payload_we = 1.
  - wdata_valid = axi_w_valid and axi_w_ready = wdata_ready, both gated by dat_cnt <= len.
  - wdata_first = (dat_cnt == 0). wdata_last = (dat_cnt == len). The AXI wlast input is ignored.
  - When both counters are done, go to WRESP.
- WRESP: b_valid = 1, resp = 2'b00, id = latched id. On b_ready go to IDLE.
- READ: cmd_cnt issues len+1 commands with payload_we = 0. rdata passes through: r_valid = rdata_valid, rdata_ready = r_ready, data forwarded.
  - r_first = (rd_cnt == 0), r_last = (rd_cnt == len), resp = 00, id = latched id.
  - After the final r handshake, go to IDLE.
- native_cmd_first = (cmd_cnt == 0). native_cmd_last = (cmd_cnt == len).
- Address step per accepted native_cmd:
  - FIXED (00): address unchanged.
  - INCR (01) and reserved (11): address + 1, modulo 2^ADDR_W (wraps silently).
  - WRAP (10): mask = len; next = (a & ~mask) | ((a + 1) & mask). Valid for len 1, 3, 7, 15; any other len is treated as INCR.
- Size is ignored. Every beat is DATA_W wide.

## Timing
- Reset values:
  - state = IDLE, last_grant = read, all counters 0, latched address/len/id 0.
  - Every valid and ready output = 0; first/last = 0; payloads = 0.
- AW/AR handshake in cycle N → native_cmd_valid = 1 in cycle N+1 (registered).
- Commands are issued back-to-back, one per cycle while native_cmd_ready is high. native_cmd_valid and its payload hold until ready.
- W→wdata and rdata→R are combinational pass-throughs (0 latency). The bridge adds no buffering.
- Final wdata handshake and final cmd handshake complete by cycle M → b_valid = 1 in cycle M+1 (if they complete in different cycles, M is the later one).
- b_valid holds until b_ready. At most one burst is outstanding, so the next AW/AR is accepted no earlier than the cycle after the B or last-R handshake.
- Commands may lead data by any amount within the burst. wdata may lead commands; native ordering is the port's responsibility.
- Simultaneous aw_valid and ar_valid in IDLE: only one ready is asserted.
- Reset asserted mid-burst: immediate return to IDLE with all outputs at reset values. The burst is dropped and no B/R is produced.

## Test plan
- Single write: aw addr 0x40, len 0, INCR, id 1; one W beat with strb all-ones → native cmd we=1, addr 0x2, first = last = 1; wdata last = 1; then b_valid resp 00, id 1.
- INCR read: ar addr 0x100, len 3 → cmds at addrs 0x8, 0x9, 0xA, 0xB; 4 R beats with data in order, r_last only on beat 3.
- WRAP read: addr 0xC0 (word 6), len 3 → cmd addrs 6, 7, 4, 5.
- Backpressure: native_cmd_ready and r_ready toggled randomly → no lost or duplicated beats; payload stable while valid && !ready.
- Arbitration: aw and ar both valid in the same cycle from reset → write granted first, read next. Repeat both-valid → alternates.
- Reset asserted during beat 2 of a len 7 write → all outputs 0 the next cycle. A new write after release completes normally.

Source files
------------

// File: rtl/axi_to_native_bridge.sv
// axi_to_native_bridge
// Splits one AXI4 burst at a time into per-beat LiteDRAM native-port
// transactions. Writes and reads share the native port under round-robin
// arbitration. W->wdata and rdata->R are zero-latency pass-throughs.
//
// Ports
//   sys_clk, sys_rst (async, active-low)
//   axi_aw_* / axi_ar_*  : burst address channels (lock/prot/cache/qos absent)
//   axi_w_*              : write beats (wlast and id ignored)
//   axi_b_*              : single write response per burst
//   axi_r_*              : read beats, forwarded from rdata
//   native_cmd_*         : one command per beat, word address
//   wdata_* / rdata_*    : native data streams
module axi_to_native_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic                sys_clk,
  input  logic                sys_rst,

  input  logic                axi_aw_valid,
  output logic                axi_aw_ready,
  input  logic [ADDR_W-1:0]   axi_aw_payload_addr,
  input  logic [1:0]          axi_aw_payload_burst,
  input  logic [7:0]          axi_aw_payload_len,
  input  logic [3:0]          axi_aw_payload_size,
  input  logic                axi_aw_payload_id,

  input  logic                axi_w_valid,
  output logic                axi_w_ready,
  input  logic                axi_w_last,
  input  logic [DATA_W-1:0]   axi_w_payload_data,
  input  logic [DATA_W/8-1:0] axi_w_payload_strb,
  input  logic                axi_w_payload_id,

  output logic                axi_b_valid,
  input  logic                axi_b_ready,
  output logic                axi_b_first,
  output logic                axi_b_last,
  output logic [1:0]          axi_b_payload_resp,
  output logic                axi_b_payload_id,

  input  logic                axi_ar_valid,
  output logic                axi_ar_ready,
  input  logic [ADDR_W-1:0]   axi_ar_payload_addr,
  input  logic [1:0]          axi_ar_payload_burst,
  input  logic [7:0]          axi_ar_payload_len,
  input  logic [3:0]          axi_ar_payload_size,
  input  logic                axi_ar_payload_id,

  output logic                axi_r_valid,
  input  logic                axi_r_ready,
  output logic                axi_r_first,
  output logic                axi_r_last,
  output logic [1:0]          axi_r_payload_resp,
  output logic [DATA_W-1:0]   axi_r_payload_data,
  output logic                axi_r_payload_id,

  output logic                native_cmd_valid,
  input  logic                native_cmd_ready,
  output logic                native_cmd_first,
  output logic                native_cmd_last,
  output logic                native_cmd_payload_we,
  output logic [ADDR_W-1:0]   native_cmd_payload_addr,

  output logic                wdata_valid,
  input  logic                wdata_ready,
  output logic                wdata_first,
  output logic                wdata_last,
  output logic [DATA_W-1:0]   wdata_payload_data,
  output logic [DATA_W/8-1:0] wdata_payload_we,

  input  logic                rdata_valid,
  output logic                rdata_ready,
  input  logic                rdata_first,
  input  logic                rdata_last,
  input  logic [DATA_W-1:0]   rdata_payload_data
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Beat counters must reach len+1 (256) to mark completion.
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t             state;
  logic               last_grant_wr;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         len_q;
  logic [1:0]         burst_q;
  logic               id_q;
  logic [CNT_W-1:0]   cmd_cnt;
  logic [CNT_W-1:0]   dat_cnt;  // wdata beats in WRITE, R beats in READ

  logic [CNT_W-1:0]   len_ext;
  logic               idle, grant_wr, grant_rd;
  logic               cmd_active, dat_open, rd_st;
  logic               cmd_fire, w_fire, r_fire;
  logic [CNT_W-1:0]   cmd_cnt_nxt, dat_cnt_nxt;
  logic [ADDR_W-1:0]  addr_inc, wrap_mask, next_addr;

  logic unused_inputs;
  assign unused_inputs = ^{axi_aw_payload_size, axi_ar_payload_size, axi_w_last,
                           axi_w_payload_id, rdata_first, rdata_last};

  assign len_ext = CNT_W'(len_q);
  assign idle    = (state == IDLE);

  // Round-robin: on a tie, grant the channel that did not win last time.
  assign grant_wr = axi_aw_valid && (!axi_ar_valid || !last_grant_wr);
  assign grant_rd = axi_ar_valid && !grant_wr;

  assign axi_aw_ready = idle && grant_wr;
  assign axi_ar_ready = idle && grant_rd;

  // Native command channel
  assign cmd_active              = ((state == WRITE) || (state == READ)) && (cmd_cnt <= len_ext);
  assign native_cmd_valid        = cmd_active;
  assign native_cmd_first        = cmd_active && (cmd_cnt == '0);
  assign native_cmd_last         = cmd_active && (cmd_cnt == len_ext);
  assign native_cmd_payload_we   = cmd_active && (state == WRITE);
  assign native_cmd_payload_addr = addr_q;
  assign cmd_fire                = native_cmd_valid && native_cmd_ready;

  // W -> wdata pass-through while beats remain
  assign dat_open           = (state == WRITE) && (dat_cnt <= len_ext);
  assign wdata_valid        = dat_open && axi_w_valid;
  assign axi_w_ready        = dat_open && wdata_ready;
  assign wdata_first        = dat_open && (dat_cnt == '0);
  assign wdata_last         = dat_open && (dat_cnt == len_ext);
  assign wdata_payload_data = dat_open ? axi_w_payload_data : '0;
  assign wdata_payload_we   = dat_open ? axi_w_payload_strb : STRB_W'(0);
  assign w_fire             = wdata_valid && wdata_ready;

  // rdata -> R pass-through
  assign rd_st              = (state == READ);
  assign axi_r_valid        = rd_st && rdata_valid;
  assign rdata_ready        = rd_st && axi_r_ready;
  assign axi_r_first        = rd_st && (dat_cnt == '0);
  assign axi_r_last         = rd_st && (dat_cnt == len_ext);
  assign axi_r_payload_resp = 2'b00;
  assign axi_r_payload_data = rd_st ? rdata_payload_data : '0;
  assign axi_r_payload_id   = rd_st && id_q;
  assign r_fire             = axi_r_valid && axi_r_ready;

  // Write response
  assign axi_b_valid        = (state == WRESP);
  assign axi_b_first        = axi_b_valid;
  assign axi_b_last         = axi_b_valid;
  assign axi_b_payload_resp = 2'b00;
  assign axi_b_payload_id   = axi_b_valid && id_q;

  assign cmd_cnt_nxt = cmd_cnt + CNT_W'(cmd_fire);
  assign dat_cnt_nxt = dat_cnt + CNT_W'(w_fire);

  // Next word address after an accepted command, by burst type
  always_comb begin
    addr_inc  = addr_q + ADDR_W'(1);
    wrap_mask = '0;
    next_addr = addr_inc;
    case (burst_q)
      2'b00: next_addr = addr_q;
      2'b10: begin
        // Only power-of-two beat counts wrap; other lengths step like INCR.
        if ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15)) begin
          wrap_mask = ADDR_W'(len_q);
          next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
        end
      end
      default: ;
    endcase
  end

  // Burst FSM, latched burst parameters and beat counters
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state         <= IDLE;
      last_grant_wr <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      burst_q       <= '0;
      id_q          <= 1'b0;
      cmd_cnt       <= '0;
      dat_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_cnt <= '0;
          dat_cnt <= '0;
          if (axi_aw_ready) begin
            addr_q        <= ADDR_W'(axi_aw_payload_addr >> OFFSET_W);
            len_q         <= axi_aw_payload_len;
            burst_q       <= axi_aw_payload_burst;
            id_q          <= axi_aw_payload_id;
            last_grant_wr <= 1'b1;
            state         <= WRITE;
          end else if (axi_ar_ready) begin
            addr_q        <= ADDR_W'(axi_ar_payload_addr >> OFFSET_W);
            len_q         <= axi_ar_payload_len;
            burst_q       <= axi_ar_payload_burst;
            id_q          <= axi_ar_payload_id;
            last_grant_wr <= 1'b0;
            state         <= READ;
          end
        end
        WRITE: begin
          cmd_cnt <= cmd_cnt_nxt;
          dat_cnt <= dat_cnt_nxt;
          if (cmd_fire) addr_q <= next_addr;
          if ((cmd_cnt_nxt > len_ext) && (dat_cnt_nxt > len_ext)) state <= WRESP;
        end
        WRESP: begin
          if (axi_b_ready) state <= IDLE;
        end
        READ: begin
          cmd_cnt <= cmd_cnt_nxt;
          if (cmd_fire) addr_q <= next_addr;
          if (r_fire) begin
            dat_cnt <= dat_cnt + CNT_W'(1);
            if (dat_cnt == len_ext) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_native_bridge.sv
// Directed bench for axi_to_native_bridge: arbitration, INCR/FIXED/WRAP
// addressing, backpressure, and reset in the middle of a write burst.
module tb_axi_to_native_bridge;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic sys_clk = 1'b0;
  logic sys_rst;

  logic axi_aw_valid, axi_aw_ready, axi_aw_payload_id;
  logic [ADDR_W-1:0] axi_aw_payload_addr;
  logic [1:0] axi_aw_payload_burst;
  logic [7:0] axi_aw_payload_len;
  logic [3:0] axi_aw_payload_size;

  logic axi_w_valid, axi_w_ready, axi_w_last, axi_w_payload_id;
  logic [DATA_W-1:0] axi_w_payload_data;
  logic [STRB_W-1:0] axi_w_payload_strb;

  logic axi_b_valid, axi_b_ready, axi_b_first, axi_b_last, axi_b_payload_id;
  logic [1:0] axi_b_payload_resp;

  logic axi_ar_valid, axi_ar_ready, axi_ar_payload_id;
  logic [ADDR_W-1:0] axi_ar_payload_addr;
  logic [1:0] axi_ar_payload_burst;
  logic [7:0] axi_ar_payload_len;
  logic [3:0] axi_ar_payload_size;

  logic axi_r_valid, axi_r_ready, axi_r_first, axi_r_last, axi_r_payload_id;
  logic [1:0] axi_r_payload_resp;
  logic [DATA_W-1:0] axi_r_payload_data;

  logic native_cmd_valid, native_cmd_ready, native_cmd_first, native_cmd_last, native_cmd_payload_we;
  logic [ADDR_W-1:0] native_cmd_payload_addr;

  logic wdata_valid, wdata_ready, wdata_first, wdata_last;
  logic [DATA_W-1:0] wdata_payload_data;
  logic [STRB_W-1:0] wdata_payload_we;

  logic rdata_valid, rdata_ready, rdata_first, rdata_last;
  logic [DATA_W-1:0] rdata_payload_data;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_addr [16];

  axi_to_native_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_payload_addr(axi_aw_payload_addr), .axi_aw_payload_burst(axi_aw_payload_burst),
    .axi_aw_payload_len(axi_aw_payload_len), .axi_aw_payload_size(axi_aw_payload_size),
    .axi_aw_payload_id(axi_aw_payload_id),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_last(axi_w_last),
    .axi_w_payload_data(axi_w_payload_data), .axi_w_payload_strb(axi_w_payload_strb),
    .axi_w_payload_id(axi_w_payload_id),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_first(axi_b_first),
    .axi_b_last(axi_b_last), .axi_b_payload_resp(axi_b_payload_resp), .axi_b_payload_id(axi_b_payload_id),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_payload_addr(axi_ar_payload_addr), .axi_ar_payload_burst(axi_ar_payload_burst),
    .axi_ar_payload_len(axi_ar_payload_len), .axi_ar_payload_size(axi_ar_payload_size),
    .axi_ar_payload_id(axi_ar_payload_id),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_first(axi_r_first),
    .axi_r_last(axi_r_last), .axi_r_payload_resp(axi_r_payload_resp),
    .axi_r_payload_data(axi_r_payload_data), .axi_r_payload_id(axi_r_payload_id),
    .native_cmd_valid(native_cmd_valid), .native_cmd_ready(native_cmd_ready),
    .native_cmd_first(native_cmd_first), .native_cmd_last(native_cmd_last),
    .native_cmd_payload_we(native_cmd_payload_we), .native_cmd_payload_addr(native_cmd_payload_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_first(wdata_first),
    .wdata_last(wdata_last), .wdata_payload_data(wdata_payload_data), .wdata_payload_we(wdata_payload_we),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_first(rdata_first),
    .rdata_last(rdata_last), .rdata_payload_data(rdata_payload_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one AW, stream cmd/W beats (optionally with random stalls), then take B.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input bit rnd);
    int ci, di, cyc, lenv;
    logic [31:0] strb;
    ci = 0; di = 0; cyc = 0; lenv = int'(len);
    axi_aw_payload_addr = addr; axi_aw_payload_len = len;
    axi_aw_payload_burst = burst; axi_aw_payload_id = id; axi_aw_valid = 1'b1;
    #1;
    check_eq("aw_ready", 256'(axi_aw_ready), 256'(1));
    check_eq("ar_ready_blocked", 256'(axi_ar_ready), 256'(0));
    tick();
    axi_aw_valid = 1'b0;
    while ((ci <= lenv || di <= lenv) && cyc < 400) begin
      native_cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_ready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_w_valid      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_w_payload_data = {8{32'hD000_0000 + 32'(di)}};
      strb = 32'hFFFF_FFFF ^ 32'(di);
      axi_w_payload_strb = strb;
      #1;
      check_eq("wr_cmd_valid", 256'(native_cmd_valid), 256'(ci <= lenv));
      if (ci <= lenv) begin
        check_eq("wr_cmd_addr", 256'(native_cmd_payload_addr), 256'(exp_addr[ci]));
        check_eq("wr_cmd_we", 256'(native_cmd_payload_we), 256'(1));
        check_eq("wr_cmd_first", 256'(native_cmd_first), 256'(ci == 0));
        check_eq("wr_cmd_last", 256'(native_cmd_last), 256'(ci == lenv));
      end
      check_eq("wdata_valid", 256'(wdata_valid), 256'(axi_w_valid && di <= lenv));
      check_eq("w_ready", 256'(axi_w_ready), 256'(wdata_ready && di <= lenv));
      check_eq("ar_ready_busy", 256'(axi_ar_ready), 256'(0));
      if (axi_w_valid && di <= lenv) begin
        check_eq("wdata_data", wdata_payload_data, {8{32'hD000_0000 + 32'(di)}});
        check_eq("wdata_we", 256'(wdata_payload_we), 256'(strb));
        check_eq("wdata_first", 256'(wdata_first), 256'(di == 0));
        check_eq("wdata_last", 256'(wdata_last), 256'(di == lenv));
      end
      if (ci <= lenv && native_cmd_ready) ci++;
      if (di <= lenv && axi_w_valid && wdata_ready) di++;
      tick();
      cyc++;
    end
    axi_w_valid = 1'b0;
    check_eq("wr_done_in_budget", 256'(ci > lenv && di > lenv), 256'(1));
    check_eq("b_valid", 256'(axi_b_valid), 256'(1));
    check_eq("b_resp", 256'(axi_b_payload_resp), 256'(0));
    check_eq("b_id", 256'(axi_b_payload_id), 256'(id));
    check_eq("b_last", 256'(axi_b_last), 256'(1));
    check_eq("b_cmd_idle", 256'(native_cmd_valid), 256'(0));
    if (rnd) begin
      tick();
      check_eq("b_valid_hold", 256'(axi_b_valid), 256'(1));
    end
    axi_b_ready = 1'b1;
    tick();
    axi_b_ready = 1'b0;
    check_eq("b_valid_clear", 256'(axi_b_valid), 256'(0));
  endtask

  // Issue one AR, issue commands and return R beats only for issued commands.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic id, input bit rnd);
    int ci, ri, cyc, lenv;
    ci = 0; ri = 0; cyc = 0; lenv = int'(len);
    axi_ar_payload_addr = addr; axi_ar_payload_len = len;
    axi_ar_payload_burst = burst; axi_ar_payload_id = id; axi_ar_valid = 1'b1;
    #1;
    check_eq("ar_ready", 256'(axi_ar_ready), 256'(1));
    check_eq("aw_ready_blocked", 256'(axi_aw_ready), 256'(0));
    tick();
    axi_ar_valid = 1'b0;
    while (ri <= lenv && cyc < 400) begin
      native_cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_r_ready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata_valid      = (ri < ci) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      rdata_payload_data = {8{32'hB000_0000 + 32'(ri)}};
      rdata_first = (ri == 0);
      rdata_last  = (ri == lenv);
      #1;
      check_eq("rd_cmd_valid", 256'(native_cmd_valid), 256'(ci <= lenv));
      if (ci <= lenv) begin
        check_eq("rd_cmd_addr", 256'(native_cmd_payload_addr), 256'(exp_addr[ci]));
        check_eq("rd_cmd_we", 256'(native_cmd_payload_we), 256'(0));
        check_eq("rd_cmd_first", 256'(native_cmd_first), 256'(ci == 0));
        check_eq("rd_cmd_last", 256'(native_cmd_last), 256'(ci == lenv));
      end
      check_eq("r_valid", 256'(axi_r_valid), 256'(rdata_valid));
      check_eq("rdata_ready", 256'(rdata_ready), 256'(axi_r_ready));
      check_eq("aw_ready_busy", 256'(axi_aw_ready), 256'(0));
      if (rdata_valid) begin
        check_eq("r_data", axi_r_payload_data, {8{32'hB000_0000 + 32'(ri)}});
        check_eq("r_first", 256'(axi_r_first), 256'(ri == 0));
        check_eq("r_last", 256'(axi_r_last), 256'(ri == lenv));
        check_eq("r_resp", 256'(axi_r_payload_resp), 256'(0));
        check_eq("r_id", 256'(axi_r_payload_id), 256'(id));
      end
      if (ci <= lenv && native_cmd_ready) ci++;
      if (rdata_valid && axi_r_ready) ri++;
      tick();
      cyc++;
    end
    rdata_valid = 1'b0;
    axi_r_ready = 1'b0;
    check_eq("rd_done_in_budget", 256'(ri), 256'(lenv + 1));
    check_eq("rd_cmd_count", 256'(ci), 256'(lenv + 1));
    check_eq("rd_cmd_idle", 256'(native_cmd_valid), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b0;
    axi_aw_valid = 0; axi_aw_payload_addr = '0; axi_aw_payload_burst = 2'b01;
    axi_aw_payload_len = '0; axi_aw_payload_size = 4'd5; axi_aw_payload_id = 0;
    axi_w_valid = 0; axi_w_last = 0; axi_w_payload_data = '0; axi_w_payload_strb = '0; axi_w_payload_id = 0;
    axi_b_ready = 0;
    axi_ar_valid = 0; axi_ar_payload_addr = '0; axi_ar_payload_burst = 2'b01;
    axi_ar_payload_len = '0; axi_ar_payload_size = 4'd5; axi_ar_payload_id = 0;
    axi_r_ready = 0;
    native_cmd_ready = 0; wdata_ready = 0;
    rdata_valid = 0; rdata_first = 0; rdata_last = 0; rdata_payload_data = '0;
    for (int i = 0; i < 16; i++) exp_addr[i] = '0;

    repeat (3) tick();
    check_eq("rst_cmd_valid", 256'(native_cmd_valid), 256'(0));
    check_eq("rst_cmd_addr", 256'(native_cmd_payload_addr), 256'(0));
    check_eq("rst_b_valid", 256'(axi_b_valid), 256'(0));
    check_eq("rst_aw_ready", 256'(axi_aw_ready), 256'(0));
    sys_rst = 1'b1;
    tick();

    // Tie from reset: write wins, read queued behind it
    axi_ar_payload_addr = 32'h100; axi_ar_payload_len = 8'd3;
    axi_ar_payload_burst = 2'b01; axi_ar_payload_id = 1'b0; axi_ar_valid = 1'b1;
    exp_addr[0] = 32'h2;
    do_write(32'h40, 8'd0, 2'b01, 1'b1, 1'b0);

    // INCR read 0x100 len 3
    exp_addr[0] = 32'h8; exp_addr[1] = 32'h9; exp_addr[2] = 32'hA; exp_addr[3] = 32'hB;
    do_read(32'h100, 8'd3, 2'b01, 1'b0, 1'b0);

    // Tie after a read: write wins; FIXED burst keeps the address
    axi_ar_payload_addr = 32'hC0; axi_ar_payload_len = 8'd3;
    axi_ar_payload_burst = 2'b10; axi_ar_payload_id = 1'b1; axi_ar_valid = 1'b1;
    exp_addr[0] = 32'h18; exp_addr[1] = 32'h18; exp_addr[2] = 32'h18;
    do_write(32'h300, 8'd2, 2'b00, 1'b0, 1'b0);

    // Tie after a write: read wins; WRAP read from word 6
    axi_aw_payload_addr = 32'h200; axi_aw_payload_len = 8'd7;
    axi_aw_payload_burst = 2'b01; axi_aw_payload_id = 1'b0; axi_aw_valid = 1'b1;
    exp_addr[0] = 32'h6; exp_addr[1] = 32'h7; exp_addr[2] = 32'h4; exp_addr[3] = 32'h5;
    do_read(32'hC0, 8'd3, 2'b10, 1'b1, 1'b0);

    // Pending len 7 write is accepted, then reset hits on beat 2
    #1;
    check_eq("mid_aw_ready", 256'(axi_aw_ready), 256'(1));
    tick();
    axi_aw_valid = 1'b0;
    native_cmd_ready = 1'b1; wdata_ready = 1'b1; axi_w_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      axi_w_payload_data = {8{32'hD000_0000 + 32'(b)}};
      #1;
      check_eq("mid_cmd_addr", 256'(native_cmd_payload_addr), 256'(32'h10 + 32'(b)));
      check_eq("mid_wdata_valid", 256'(wdata_valid), 256'(1));
      tick();
    end
    check_eq("mid_beat2_addr", 256'(native_cmd_payload_addr), 256'(32'h12));
    sys_rst = 1'b0;
    #1;
    check_eq("arst_cmd_valid", 256'(native_cmd_valid), 256'(0));
    check_eq("arst_cmd_addr", 256'(native_cmd_payload_addr), 256'(0));
    check_eq("arst_wdata_valid", 256'(wdata_valid), 256'(0));
    check_eq("arst_w_ready", 256'(axi_w_ready), 256'(0));
    tick();
    check_eq("arst_cmd_first", 256'(native_cmd_first), 256'(0));
    check_eq("arst_wdata_we", 256'(wdata_payload_we), 256'(0));
    sys_rst = 1'b1;
    axi_w_valid = 1'b0;
    tick();
    check_eq("post_rst_no_b", 256'(axi_b_valid), 256'(0));
    check_eq("post_rst_cmd_idle", 256'(native_cmd_valid), 256'(0));

    // Backpressured WRAP write from word 0x1E
    exp_addr[0] = 32'h1E; exp_addr[1] = 32'h1F;
    for (int i = 2; i < 8; i++) exp_addr[i] = 32'h18 + 32'(i - 2);
    do_write(32'h3C0, 8'd7, 2'b10, 1'b1, 1'b1);

    // Backpressured WRAP read with len 2: steps like INCR
    exp_addr[0] = 32'h1; exp_addr[1] = 32'h2; exp_addr[2] = 32'h3;
    do_read(32'h20, 8'd2, 2'b10, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
